// File: rtl/commit_trace_buf_pkg.sv
// commit_trace_buf_pkg: shared types and entry-width helper for the commit trace recorder.
package commit_trace_buf_pkg;
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} trace_state_e;
    typedef enum logic [1:0] {TC_NONE = 2'd0, TC_MANUAL = 2'd1, TC_WDOG = 2'd2, TC_LIMIT = 2'd3} trig_cause_e;
    function automatic int entry_w(input int cyc_w, input int rob_w);
        return 1 + cyc_w + 32 + rob_w + 5 + 1 + 4;
    endfunction
    // Decoded view of an entry at the default CYC_W=32, ROB_W=5 widths.
    typedef struct packed {
        logic        kind;
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [4:0]  rob;
        logic [4:0]  rd_arch;
        logic        uses_rd;
        logic [3:0]  flags;
    } trace_entry_t;
endpackage

// File: rtl/commit_trace_buf_if.sv
// commit_trace_buf_if: core retire/flush event inputs plus the valid/ready drain port.
interface commit_trace_buf_if #(parameter int ROB_W = 5, parameter int ENTRY_W = 80);
    logic               commit_fire_i;
    logic [31:0]        commit_pc_i;
    logic [ROB_W-1:0]   commit_rob_i;
    logic [4:0]         commit_rd_arch_i;
    logic               commit_uses_rd_i;
    logic [3:0]         commit_flags_i;
    logic               flush_valid_i;
    logic [ROB_W-1:0]   flush_rob_i;
    logic               rd_valid_o;
    logic               rd_ready_i;
    logic [ENTRY_W-1:0] rd_entry_o;
    modport master (output commit_fire_i, commit_pc_i, commit_rob_i, commit_rd_arch_i, commit_uses_rd_i,
                    commit_flags_i, flush_valid_i, flush_rob_i, rd_ready_i, input rd_valid_o, rd_entry_o);
    modport slave (input commit_fire_i, commit_pc_i, commit_rob_i, commit_rd_arch_i, commit_uses_rd_i,
                   commit_flags_i, flush_valid_i, flush_rob_i, rd_ready_i, output rd_valid_o, rd_entry_o);
endinterface

// File: rtl/commit_trace_buf_ring.sv
// trace_ring: flop-array ring storage with two adjacent write ports and one async read port.
module trace_ring #(
    parameter int DEPTH = 64,
    parameter int W     = 80
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wd0,
    input  logic [W-1:0]             wd1,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rd
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we0) mem[waddr] <= wd0;
        if (we1) mem[AW'(waddr + 1'b1)] <= wd1;
    end
    assign rd = mem[raddr];
endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: ring-buffer trace of commits/flushes that freezes on a trigger
// and then drains its contents oldest-first over a valid/ready port.
module commit_trace_buf
    import commit_trace_buf_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int ROB_W        = 5,
    parameter int CYC_W        = 32,
    parameter int WDOG_CYCLES  = 5000,
    parameter int COMMIT_LIMIT = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    commit_trace_buf_if.slave  bus,
    input  logic               freeze_i,
    input  logic               clear_i,
    output logic [1:0]         state_o,
    output logic [1:0]         trig_cause_o,
    output logic [31:0]        commits_o,
    output logic [15:0]        overwritten_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = WDOG_CYCLES > 0 ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam int EW = entry_w(CYC_W, ROB_W);
    trace_state_e   state, state_n;
    trig_cause_e    cause, cause_n;
    logic [AW-1:0]  wptr, wptr_n;
    logic [CW-1:0]  count, count_n;
    logic [CW:0]    sum;
    logic [IW-1:0]  idle, idle_n, idle_inc;
    logic [31:0]    commits_n, commits_inc;
    logic [15:0]    ovf_n;
    logic [16:0]    ovf_sum;
    logic [CYC_W-1:0] cyc;
    logic [1:0]     n_wr;
    logic           commit, flush, wd, lim, we0, we1;
    logic [EW-1:0]  c_ent, f_ent;
    assign commit      = bus.commit_fire_i;
    assign flush       = bus.flush_valid_i;
    assign n_wr        = {1'b0, commit} + {1'b0, flush};
    assign sum         = (CW+1)'(count) + (CW+1)'(n_wr);
    // Writes beyond a full ring each displace one oldest entry.
    assign ovf_sum     = 17'(overwritten_o) + 17'(sum > (CW+1)'(DEPTH) ? sum - (CW+1)'(DEPTH) : '0);
    assign idle_inc    = idle == IW'(WDOG_CYCLES) ? idle : idle + 1'b1;
    assign commits_inc = commits_o + 32'(commit);
    assign wd          = WDOG_CYCLES != 0 && !commit && idle_inc == IW'(WDOG_CYCLES);
    assign lim         = COMMIT_LIMIT != 0 && commits_inc == 32'(COMMIT_LIMIT);
    assign c_ent       = {1'b0, cyc, bus.commit_pc_i, bus.commit_rob_i, bus.commit_rd_arch_i,
                          bus.commit_uses_rd_i, bus.commit_flags_i};
    assign f_ent       = {1'b1, cyc, 32'd0, bus.flush_rob_i, 10'd0};
    trace_ring #(.DEPTH(DEPTH), .W(EW)) u_ring (
        .clk(clk), .we0(we0), .we1(we1), .waddr(wptr),
        .wd0(commit ? c_ent : f_ent), .wd1(f_ent),
        .raddr(wptr - AW'(count)), .rd(bus.rd_entry_o)
    );
    always_comb begin
        state_n   = state;
        cause_n   = cause;
        wptr_n    = wptr;
        count_n   = count;
        idle_n    = idle;
        commits_n = commits_o;
        ovf_n     = overwritten_o;
        we0       = 1'b0;
        we1       = 1'b0;
        if (clear_i) begin
            state_n   = ST_RUN;
            cause_n   = TC_NONE;
            count_n   = '0;
            idle_n    = '0;
            commits_n = '0;
            ovf_n     = '0;
        end else if (state == ST_RUN) begin
            we0       = commit | flush;
            we1       = commit & flush;
            wptr_n    = wptr + AW'(n_wr);
            count_n   = sum > (CW+1)'(DEPTH) ? CW'(DEPTH) : CW'(sum);
            ovf_n     = ovf_sum[16] ? 16'hffff : ovf_sum[15:0];
            idle_n    = commit ? '0 : idle_inc;
            commits_n = commits_inc;
            cause_n   = freeze_i ? TC_MANUAL : wd ? TC_WDOG : lim ? TC_LIMIT : TC_NONE;
            if (cause_n != TC_NONE) state_n = count_n != '0 ? ST_DRAIN : ST_DONE;
        end else if (state == ST_DRAIN && bus.rd_ready_i) begin
            count_n = count - 1'b1;
            if (count_n == '0) state_n = ST_DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            cause         <= TC_NONE;
            wptr          <= '0;
            count         <= '0;
            idle          <= '0;
            commits_o     <= '0;
            overwritten_o <= '0;
            cyc           <= '0;
        end else begin
            state         <= state_n;
            cause         <= cause_n;
            wptr          <= wptr_n;
            count         <= count_n;
            idle          <= idle_n;
            commits_o     <= commits_n;
            overwritten_o <= ovf_n;
            cyc           <= cyc + 1'b1;
        end
    end
    assign bus.rd_valid_o = state == ST_DRAIN;
    assign state_o        = state;
    assign trig_cause_o   = cause;
endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: scoreboard bench; dut_a (watchdog 20) and dut_b (limit 8) share stimulus.
module tb_commit_trace_buf;
    import commit_trace_buf_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic c_fire, c_uses, f_valid, freeze, clear, ready;
    logic [31:0] c_pc;
    logic [4:0] c_rob, c_rd, f_rob;
    logic [3:0] c_flags;
    logic [1:0] a_state, a_cause, b_state, b_cause;
    logic [31:0] a_commits, b_commits, tcyc;
    logic [15:0] a_ovf, b_ovf;
    trace_entry_t sbq[$], got[$];
    int passed = 0, total = 0;
    commit_trace_buf_if #(.ROB_W(5), .ENTRY_W(80)) a_if ();
    commit_trace_buf_if #(.ROB_W(5), .ENTRY_W(80)) b_if ();
    assign a_if.commit_fire_i = c_fire;  assign b_if.commit_fire_i = c_fire;
    assign a_if.commit_pc_i = c_pc;      assign b_if.commit_pc_i = c_pc;
    assign a_if.commit_rob_i = c_rob;    assign b_if.commit_rob_i = c_rob;
    assign a_if.commit_rd_arch_i = c_rd; assign b_if.commit_rd_arch_i = c_rd;
    assign a_if.commit_uses_rd_i = c_uses; assign b_if.commit_uses_rd_i = c_uses;
    assign a_if.commit_flags_i = c_flags; assign b_if.commit_flags_i = c_flags;
    assign a_if.flush_valid_i = f_valid; assign b_if.flush_valid_i = f_valid;
    assign a_if.flush_rob_i = f_rob;     assign b_if.flush_rob_i = f_rob;
    assign a_if.rd_ready_i = ready;      assign b_if.rd_ready_i = ready;
    commit_trace_buf #(.DEPTH(64), .ROB_W(5), .CYC_W(32), .WDOG_CYCLES(20), .COMMIT_LIMIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .freeze_i(freeze), .clear_i(clear),
        .state_o(a_state), .trig_cause_o(a_cause), .commits_o(a_commits), .overwritten_o(a_ovf));
    commit_trace_buf #(.DEPTH(64), .ROB_W(5), .CYC_W(32), .WDOG_CYCLES(0), .COMMIT_LIMIT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .freeze_i(freeze), .clear_i(clear),
        .state_o(b_state), .trig_cause_o(b_cause), .commits_o(b_commits), .overwritten_o(b_ovf));
    // Reference cycle stamp: same reset and increment rule as the recorder's stamp.
    always @(posedge clk) tcyc <= !rst_n ? 32'd0 : tcyc + 32'd1;
    task automatic cycle(input logic cf, input logic [31:0] pc, input logic [4:0] rob,
                         input logic fv, input logic [4:0] frob, input logic frz, input logic clr);
        trace_entry_t e;
        @(negedge clk);
        c_fire = cf; c_pc = pc; c_rob = rob; c_rd = pc[6:2]; c_uses = pc[3]; c_flags = pc[5:2];
        f_valid = fv; f_rob = frob; freeze = frz; clear = clr;
        if (cf && !clr) begin
            e = '0; e.cycle = tcyc; e.pc = pc; e.rob = rob; e.rd_arch = pc[6:2]; e.uses_rd = pc[3]; e.flags = pc[5:2];
            sbq.push_back(e);
        end
        if (fv && !clr) begin
            e = '0; e.kind = 1'b1; e.cycle = tcyc; e.rob = frob;
            sbq.push_back(e);
        end
    endtask
    task automatic idle_step();
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask
    task automatic commit(input logic [31:0] pc, input logic [4:0] rob);
        cycle(1'b1, pc, rob, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask
    task automatic drain(input bit sel, input bit toggle, output int errs);
        trace_entry_t cur, prev;
        bit prev_stall = 1'b0;
        got.delete();
        errs = 1;
        prev = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!(sel ? b_if.rd_valid_o : a_if.rd_valid_o)) begin
                errs = errs - 1;
                break;
            end
            cur = sel ? b_if.rd_entry_o : a_if.rd_entry_o;
            if (prev_stall && cur !== prev) errs++;
            ready = toggle ? (k % 2 == 0) : 1'b1;
            if (ready) got.push_back(cur);
            prev = cur;
            prev_stall = !ready;
        end
        ready = 1'b0;
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (a_state !== 2'd0) $display("FAIL reset a_state got=%0d exp=0", a_state); else passed++;
        total++; if (a_cause !== 2'd0) $display("FAIL reset a_cause got=%0d exp=0", a_cause); else passed++;
        total++; if (a_commits !== 32'd0) $display("FAIL reset a_commits got=%0d exp=0", a_commits); else passed++;
        total++; if (a_ovf !== 16'd0) $display("FAIL reset a_ovf got=%0d exp=0", a_ovf); else passed++;
        total++; if (a_if.rd_valid_o !== 1'b0) $display("FAIL reset a_valid got=%b exp=0", a_if.rd_valid_o); else passed++;
        total++; if (b_state !== 2'd0 || b_if.rd_valid_o !== 1'b0) $display("FAIL reset b state=%0d valid=%b exp=0/0", b_state, b_if.rd_valid_o); else passed++;
    endtask
    task automatic test_basic();
        int errs;
        trace_entry_t exp;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        for (int i = 0; i < 10; i++) commit(32'h100 + 32'(4 * i), 5'(i));
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        total++; if (a_state !== 2'd1) $display("FAIL basic state got=%0d exp=1", a_state); else passed++;
        total++; if (a_cause !== 2'd1) $display("FAIL basic cause got=%0d exp=1", a_cause); else passed++;
        total++; if (a_commits !== 32'd10) $display("FAIL basic commits got=%0d exp=10", a_commits); else passed++;
        drain(1'b0, 1'b0, errs);
        total++; if (got.size() !== 10 || errs !== 0) $display("FAIL basic drained got=%0d/%0d exp=10/0", got.size(), errs); else passed++;
        foreach (got[i]) begin
            exp = sbq.size() != 0 ? sbq.pop_front() : 'x;
            total++; if (got[i] !== exp) $display("FAIL basic entry %0d got=%h exp=%h", i, got[i], exp); else passed++;
        end
        total++; if (a_state !== 2'd2 || a_if.rd_valid_o !== 1'b0) $display("FAIL basic done state=%0d valid=%b exp=2/0", a_state, a_if.rd_valid_o); else passed++;
    endtask
    task automatic test_wrap();
        int errs;
        trace_entry_t exp;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        for (int i = 0; i < 100; i++) commit(32'h1000 + 32'(4 * i), 5'(i));
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        total++; if (a_ovf !== 16'd36) $display("FAIL wrap overwritten got=%0d exp=36", a_ovf); else passed++;
        repeat (36) void'(sbq.pop_front());
        drain(1'b0, 1'b0, errs);
        total++; if (got.size() !== 64 || errs !== 0) $display("FAIL wrap drained got=%0d/%0d exp=64/0", got.size(), errs); else passed++;
        total++; if (got.size() == 0 || got[0].pc !== 32'h1000 + 32'd144) $display("FAIL wrap first_pc got=%h exp=%h", got.size() ? got[0].pc : 32'hx, 32'h1090); else passed++;
        foreach (got[i]) begin
            exp = sbq.size() != 0 ? sbq.pop_front() : 'x;
            total++; if (got[i] !== exp) $display("FAIL wrap entry %0d got=%h exp=%h", i, got[i], exp); else passed++;
        end
    endtask
    task automatic test_watchdog();
        int errs, k;
        trace_entry_t exp;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        for (int i = 0; i < 5; i++) commit(32'h2000 + 32'(4 * i), 5'(i + 7));
        for (k = 1; k <= 100; k++) begin
            idle_step();
            if (a_state !== 2'd0) break;
        end
        total++; if (k - 1 !== 20) $display("FAIL wdog edges_after_last_commit got=%0d exp=20", k - 1); else passed++;
        total++; if (a_cause !== 2'd2) $display("FAIL wdog cause got=%0d exp=2", a_cause); else passed++;
        drain(1'b0, 1'b0, errs);
        total++; if (got.size() !== 5 || errs !== 0) $display("FAIL wdog drained got=%0d/%0d exp=5/0", got.size(), errs); else passed++;
        foreach (got[i]) begin
            exp = sbq.size() != 0 ? sbq.pop_front() : 'x;
            total++; if (got[i] !== exp) $display("FAIL wdog entry %0d got=%h exp=%h", i, got[i], exp); else passed++;
        end
    endtask
    task automatic test_same_cycle();
        int errs;
        trace_entry_t exp;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        commit(32'h300, 5'd1);
        cycle(1'b1, 32'h304, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0);
        commit(32'h308, 5'd4);
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        drain(1'b0, 1'b0, errs);
        total++; if (got.size() !== 4 || errs !== 0) $display("FAIL same drained got=%0d/%0d exp=4/0", got.size(), errs); else passed++;
        total++; if (got.size() < 3 || got[2].kind !== 1'b1 || got[1].kind !== 1'b0) $display("FAIL same kinds got=%0d exp=4 entries commit-then-flush", got.size()); else passed++;
        foreach (got[i]) begin
            exp = sbq.size() != 0 ? sbq.pop_front() : 'x;
            total++; if (got[i] !== exp) $display("FAIL same entry %0d got=%h exp=%h", i, got[i], exp); else passed++;
        end
    endtask
    task automatic test_limit();
        int errs;
        trace_entry_t exp;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        for (int i = 0; i < 8; i++) commit(32'h4000 + 32'(4 * i), 5'(i));
        total++; if (b_state !== 2'd0) $display("FAIL limit early_state got=%0d exp=0", b_state); else passed++;
        idle_step();
        total++; if (b_state !== 2'd1 || b_cause !== 2'd3) $display("FAIL limit trigger state=%0d cause=%0d exp=1/3", b_state, b_cause); else passed++;
        total++; if (b_commits !== 32'd8) $display("FAIL limit commits got=%0d exp=8", b_commits); else passed++;
        drain(1'b1, 1'b1, errs);
        total++; if (got.size() !== 8 || errs !== 0) $display("FAIL limit drained got=%0d/%0d exp=8/0", got.size(), errs); else passed++;
        foreach (got[i]) begin
            exp = sbq.size() != 0 ? sbq.pop_front() : 'x;
            total++; if (got[i] !== exp) $display("FAIL limit entry %0d got=%h exp=%h", i, got[i], exp); else passed++;
        end
    endtask
    task automatic test_clear();
        int errs;
        trace_entry_t exp;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        for (int i = 0; i < 6; i++) commit(32'h5000 + 32'(4 * i), 5'(i));
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = sbq.pop_front();
            total++; if (a_if.rd_entry_o !== exp) $display("FAIL clear pop %0d got=%h exp=%h", i, a_if.rd_entry_o, exp); else passed++;
            ready = 1'b1;
        end
        cycle(1'b1, 32'h999, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1);
        ready = 1'b0;
        idle_step();
        total++; if (a_state !== 2'd0 || a_cause !== 2'd0) $display("FAIL clear state=%0d cause=%0d exp=0/0", a_state, a_cause); else passed++;
        total++; if (a_commits !== 32'd0 || a_if.rd_valid_o !== 1'b0) $display("FAIL clear commits=%0d valid=%b exp=0/0", a_commits, a_if.rd_valid_o); else passed++;
        sbq.delete();
        commit(32'h6000, 5'd1);
        commit(32'h6004, 5'd2);
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        drain(1'b0, 1'b0, errs);
        total++; if (got.size() !== 2 || errs !== 0) $display("FAIL clear drained got=%0d/%0d exp=2/0", got.size(), errs); else passed++;
        foreach (got[i]) begin
            exp = sbq.size() != 0 ? sbq.pop_front() : 'x;
            total++; if (got[i] !== exp) $display("FAIL clear entry %0d got=%h exp=%h", i, got[i], exp); else passed++;
        end
    endtask
    task automatic test_reset_mid();
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        sbq.delete();
        for (int i = 0; i < 4; i++) commit(32'h7000 + 32'(4 * i), 5'(i));
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (a_state !== 2'd0 || a_cause !== 2'd0) $display("FAIL rstmid state=%0d cause=%0d exp=0/0", a_state, a_cause); else passed++;
        total++; if (a_commits !== 32'd0 || a_ovf !== 16'd0 || a_if.rd_valid_o !== 1'b0) $display("FAIL rstmid commits=%0d ovf=%0d valid=%b exp=0/0/0", a_commits, a_ovf, a_if.rd_valid_o); else passed++;
        cycle(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_step();
        total++; if (a_state !== 2'd2 || a_if.rd_valid_o !== 1'b0 || a_cause !== 2'd1) $display("FAIL rstmid empty_freeze state=%0d valid=%b cause=%0d exp=2/0/1", a_state, a_if.rd_valid_o, a_cause); else passed++;
    endtask
    initial begin
        c_fire = 1'b0; c_pc = '0; c_rob = '0; c_rd = '0; c_uses = 1'b0; c_flags = '0;
        f_valid = 1'b0; f_rob = '0; freeze = 1'b0; clear = 1'b0; ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_watchdog();
        test_same_cycle();
        test_limit();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "bench timeout");
    end
endmodule
